parity_err_monitor: RTL and testbench

- Sequential stage directly downstream of the combinational dual-lane parity checker.
- Registers the two 8-bit data lanes and their expected parity bits, and recomputes both mismatches.
- Counts errors, captures the first failing word, and raises a windowed-threshold alarm interrupt with an acknowledge handshake.
- Feeds the status/interrupt fabric.

---
 rtl/parity_mon_pkg.sv | 28 ++
 rtl/par_lane_check.sv | 26 ++
 rtl/parity_err_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_parity_err_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_mon_pkg.sv
// ============================================================================
// Package     : parity_mon_pkg
// Description : Shared types and helpers for the parity error monitor:
//               monitor FSM state encoding, lane width and the even-parity
//               helper used by each lane checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_mon_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        ALARM   = 2'd1,
        HOLDOFF = 2'd2
    } mon_state_e;

    // Even-parity bit of one lane: the value that makes the total number of
    // ones (data plus parity) even.
    function automatic logic even_par(input logic [LANE_W-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/par_lane_check.sv
// ============================================================================
// Module      : par_lane_check
// Description : Combinational parity check of one data lane against its
//               expected even-parity bit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   lane_i  in  LANE_W  data lane
//   par_i   in  1       expected even-parity bit
//   mis_o   out 1       1 when the lane parity disagrees with par_i
// ============================================================================
`default_nettype none

module par_lane_check
    import parity_mon_pkg::*;
(
    input  logic [LANE_W-1:0] lane_i,
    input  logic              par_i,
    output logic              mis_o
);

    assign mis_o = even_par(lane_i) ^ par_i;

endmodule

`default_nettype wire

// File: rtl/parity_err_monitor.sv
// ============================================================================
// Module      : parity_err_monitor
// Description : Two-stage parity error monitor. Stage 1 registers the two
//               data lanes and their expected parity bits; stage 2 checks
//               them, counts errors, captures the first failing word and
//               runs a windowed threshold alarm with an ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CK          in  1      clock, rising edge
//   rst_n       in  1      asynchronous reset, active-low
//   in_valid    in  1      sample strobe
//   chk_en      in  1      check enable (0 -> sample never an error)
//   lane_a/b    in  8      data lanes
//   par_a/b     in  1      expected even-parity bits
//   clr         in  1      synchronous clear of count, sticky and capture
//   irq_ack     in  1      interrupt acknowledge (honoured in ALARM only)
//   err_pulse   out 1      one-cycle error flag
//   err_lane    out 2      {B,A} mismatch bits of the flagged sample
//   err_sticky  out 1      any error since last clear
//   err_cnt     out CNT_W  saturating total error count
//   cap_data    out 16     {lane_b,lane_a} of the first error since clear
//   irq         out 1      alarm interrupt, level
//   busy_alarm  out 1      FSM is in ALARM
// ============================================================================
`default_nettype none

module parity_err_monitor
    import parity_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int WIN_LEN    = 16,
    parameter int ERR_THRESH = 4
)(
    input  logic              CK,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              chk_en,
    input  logic [LANE_W-1:0] lane_a,
    input  logic              par_a,
    input  logic [LANE_W-1:0] lane_b,
    input  logic              par_b,
    input  logic              clr,
    input  logic              irq_ack,
    output logic              err_pulse,
    output logic [1:0]        err_lane,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [15:0]       cap_data,
    output logic              irq,
    output logic              busy_alarm
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [7:0]       C_WIN_LAST = 8'(WIN_LEN - 1);
    localparam logic [8:0]       C_THRESH   = 9'(ERR_THRESH);

    // ---------------- stage 1: input register ----------------
    logic              valid_q, chk_q, pa_q, pb_q;
    logic [LANE_W-1:0] la_q, lb_q;

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            chk_q   <= 1'b0;
            la_q    <= '0;
            pa_q    <= 1'b0;
            lb_q    <= '0;
            pb_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            chk_q   <= chk_en;
            la_q    <= lane_a;
            pa_q    <= par_a;
            lb_q    <= lane_b;
            pb_q    <= par_b;
        end
    end

    // ---------------- stage 2: check ----------------
    logic mis_a, mis_b, err;

    par_lane_check u_chk_a (.lane_i(la_q), .par_i(pa_q), .mis_o(mis_a));
    par_lane_check u_chk_b (.lane_i(lb_q), .par_i(pb_q), .mis_o(mis_b));

    assign err = valid_q & chk_q & (mis_a | mis_b);

    logic             pulse_q, pulse_d;
    logic [1:0]       lane_q, lane_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      cap_q, cap_d;

    always_comb begin
        pulse_d  = err;
        lane_d   = err ? {mis_b, mis_a} : 2'b00;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        // clr outranks a same-cycle error: that error is not counted or
        // captured, although err_pulse still reports it.
        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            cap_d    = '0;
        end else if (err) begin
            sticky_d = 1'b1;
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!sticky_q) begin
                cap_d = {lb_q, la_q};
            end
        end
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q  <= 1'b0;
            lane_q   <= 2'b00;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            cap_q    <= '0;
        end else begin
            pulse_q  <= pulse_d;
            lane_q   <= lane_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
        end
    end

    // ---------------- window / alarm FSM ----------------
    mon_state_e state_q, state_d;
    logic [7:0] win_cnt_q, win_cnt_d;
    logic [7:0] win_err_q, win_err_d;
    logic [8:0] err_sum;

    // The current sample's error is included in the threshold test, so the
    // final sample of a window can still raise the alarm.
    assign err_sum = {1'b0, win_err_q} + {8'b0, err};

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        case (state_q)
            MONITOR: begin
                if (valid_q) begin
                    if (err_sum >= C_THRESH) begin
                        state_d   = ALARM;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == C_WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                        win_err_d = err_sum[7:0];
                    end
                end
            end
            ALARM: begin
                win_cnt_d = '0;
                win_err_d = '0;
                if (irq_ack) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                win_cnt_d = '0;
                win_err_d = '0;
                state_d   = MONITOR;
            end
            default: begin
                win_cnt_d = '0;
                win_err_d = '0;
                state_d   = MONITOR;
            end
        endcase
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MONITOR;
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

    // ---------------- outputs ----------------
    assign err_pulse  = pulse_q;
    assign err_lane   = lane_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign cap_data   = cap_q;
    assign irq        = (state_q == ALARM);
    assign busy_alarm = (state_q == ALARM);

endmodule

`default_nettype wire

// File: tb/tb_parity_err_monitor.sv
// ============================================================================
// Module      : tb_parity_err_monitor
// Description : Self-checking bench for parity_err_monitor. A reference model
//               evaluates every clocked sample from the parity rules and
//               pushes expected error reports into a scoreboard queue; a
//               separate monitor pops them when err_pulse appears and also
//               compares counter, sticky, capture and alarm state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_err_monitor;

    localparam int CNT_W      = 3;
    localparam int WIN_LEN    = 16;
    localparam int ERR_THRESH = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, chk_en = 1'b0;
    logic [7:0]       lane_a = '0, lane_b = '0;
    logic             par_a = 1'b0, par_b = 1'b0;
    logic             clr = 1'b0, irq_ack = 1'b0;
    logic             err_pulse, err_sticky, irq, busy_alarm;
    logic [1:0]       err_lane;
    logic [CNT_W-1:0] err_cnt;
    logic [15:0]      cap_data;

    parity_err_monitor #(
        .CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH)
    ) dut (
        .CK(clk), .rst_n(rst_n), .in_valid(in_valid), .chk_en(chk_en),
        .lane_a(lane_a), .par_a(par_a), .lane_b(lane_b), .par_b(par_b),
        .clr(clr), .irq_ack(irq_ack), .err_pulse(err_pulse),
        .err_lane(err_lane), .err_sticky(err_sticky), .err_cnt(err_cnt),
        .cap_data(cap_data), .irq(irq), .busy_alarm(busy_alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        logic [1:0] lane;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    // sample held by the model between its arrival edge and its check edge
    bit         m_v, m_c, m_pa, m_pb;
    logic [7:0] m_la, m_lb;
    bit         m_ma, m_mb, m_err;
    int         e_cnt = 0;
    bit         e_sticky = 0;
    logic [15:0] e_cap = '0;
    int         mode = 0;      // 0 watching, 1 alarm raised, 2 one-cycle holdoff
    int         samples = 0;   // valid samples seen in the current window
    int         win_errs = 0;  // errors seen in the current window
    bit         e_irq = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_v = 0; m_c = 0; m_pa = 0; m_pb = 0; m_la = '0; m_lb = '0;
            e_cnt = 0; e_sticky = 0; e_cap = '0;
            mode = 0; samples = 0; win_errs = 0; e_irq = 0;
            sb.delete();
        end else begin
            m_ma  = (($countones(m_la) % 2) == 1) != m_pa;
            m_mb  = (($countones(m_lb) % 2) == 1) != m_pb;
            m_err = m_v && m_c && (m_ma || m_mb);
            if (m_err) sb.push_back('{cyc, {m_mb, m_ma}});
            if (clr) begin
                e_cnt = 0; e_sticky = 0; e_cap = '0;
            end else if (m_err) begin
                if (!e_sticky) e_cap = {m_lb, m_la};
                e_sticky = 1;
                if (e_cnt < CNT_MAX) e_cnt = e_cnt + 1;
            end
            case (mode)
                0: if (m_v) begin
                    samples  = samples + 1;
                    win_errs = win_errs + (m_err ? 1 : 0);
                    if (win_errs >= ERR_THRESH) begin
                        mode = 1; samples = 0; win_errs = 0;
                    end else if (samples == WIN_LEN) begin
                        samples = 0; win_errs = 0;
                    end
                end
                1: if (irq_ack) mode = 2;
                default: mode = 0;
            endcase
            e_irq = (mode == 1);
            // sample presented on this edge is checked on the next one
            m_v = in_valid; m_c = chk_en; m_la = lane_a; m_pa = par_a;
            m_lb = lane_b; m_pb = par_b;
        end
    end

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clk) begin
        if (rst_n) begin
            check("irq", irq, e_irq);
            check("busy_alarm", busy_alarm, e_irq);
            check("err_cnt", err_cnt, e_cnt);
            check("err_sticky", err_sticky, e_sticky);
            check("cap_data", cap_data, e_cap);
            if (err_pulse) begin
                if (sb.size() == 0) begin
                    check("unexpected_err_pulse", err_pulse, 0);
                end else begin
                    got = sb.pop_front();
                    check("pulse_cycle", cyc, got.due);
                    check("err_lane", err_lane, got.lane);
                end
            end else begin
                check("err_lane_idle", err_lane, 0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    got = sb.pop_front();
                    check("missing_err_pulse", err_pulse, 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit c, input logic [7:0] la, input bit pa,
                         input logic [7:0] lb, input bit pb, input bit cl, input bit ack);
        @(negedge clk);
        in_valid = v; chk_en = c; lane_a = la; par_a = pa;
        lane_b = lb; par_b = pb; clr = cl; irq_ack = ack;
    endtask

    task automatic idle(input int n, input bit ack = 0);
        for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 8'h00, 0, 0, ack);
    endtask

    task automatic good();
        drive(1, 1, 8'h03, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic bad();
        drive(1, 1, 8'h01, 0, 8'h0F, 0, 0, 0);
    endtask

    // Reset asserted between edges: outputs must drop before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 0; chk_en = 0; clr = 0; irq_ack = 0;
        #1;
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_lane", err_lane, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cap_data", cap_data, 0);
        check("rst_irq", irq, 0);
        check("rst_busy_alarm", busy_alarm, 0);
        idle(2);
        rst_n = 1;
    endtask

    initial begin
        idle(2);
        rst_n = 1;
        idle(1);

        // single error on lane A, pulse two edges after presentation
        bad();
        idle(1);
        @(negedge clk);
        check("dir_pulse", err_pulse, 1);
        check("dir_lane", err_lane, 2'b01);
        check("dir_cnt", err_cnt, 1);
        check("dir_cap", cap_data, 16'h0F01);
        check("dir_sticky", err_sticky, 1);

        // same bad sample with checking disabled, then a lane B error
        drive(1, 0, 8'h01, 0, 8'h0F, 0, 0, 0);
        drive(1, 1, 8'h03, 0, 8'h07, 0, 0, 0);
        idle(1);
        @(negedge clk);
        check("dir_lane_b", err_lane, 2'b10);
        check("dir_cnt2", err_cnt, 2);
        check("dir_cap_held", cap_data, 16'h0F01);

        // saturation: ten consecutive errors
        for (int i = 0; i < 10; i++) bad();
        idle(3);
        check("dir_saturate", err_cnt, CNT_MAX);
        idle(2, 1);
        // clr on the same edge that the error is checked
        bad();
        drive(0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        idle(1);
        check("dir_clr_pulse", err_pulse, 1);
        check("dir_clr_cnt", err_cnt, 0);
        check("dir_clr_sticky", err_sticky, 0);
        idle(3);

        // alarm handshake: errors on samples 1,5,9,15 of a fresh window
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            if (s == 1 || s == 5 || s == 9 || s == 15) bad(); else good();
        end
        idle(5);
        check("dir_irq_held", irq, 1);
        idle(1, 1);
        idle(1);
        check("dir_irq_acked", irq, 0);
        idle(3);

        // three errors in window 0, fourth on first sample of window 1
        do_reset();
        for (int s = 1; s <= 20; s++) begin
            if (s <= 3 || s == 17) bad(); else good();
        end
        idle(3);
        check("dir_win_split", irq, 0);

        // four errors in window 0, the last on its final sample
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            if (s == 2 || s >= 14) bad(); else good();
        end
        idle(3);
        check("dir_win_last", irq, 1);
        idle(1, 1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                  8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15);
        end
        idle(4);

        // reset in the middle of an alarm, then a clean sample after release
        do_reset();
        for (int i = 0; i < 4; i++) bad();
        idle(3);
        check("pre_reset_irq", irq, 1);
        do_reset();
        good();
        idle(1);
        @(negedge clk);
        check("post_reset_no_pulse", err_pulse, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
